corelet_seq: RTL and testbench

Instruction sequencer that drives the corelet's 34-bit `inst_q` bus, running one full tile job per `start` pulse:
- loads a kernel through L0 into the MAC array;
- streams activations through L0 and executes;
- drains the output FIFO into psum SRAM.

It sits between the top-level controller and the corelet. It is the transmitting end of the `inst_q` / `ofifo_valid` interface.

---
 rtl/corelet_seq.sv | 198 +++++++++++++++++++
 tb/tb_corelet_seq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/corelet_seq.sv
// corelet_seq: tile-job instruction sequencer driving the corelet inst_q bus.
// Optional drain watchdog enabled by defining CORELET_SEQ_TIMEOUT_EN.
//
// state        | meaning
// s_idle       | waiting for start
// s_k_l0       | kernel words xmem -> L0 (col+1 cycles)
// s_k_arr      | kernel L0 -> MAC array (col cycles)
// s_k_gap      | kernel settle time (row+col cycles)
// s_a_l0       | activation words xmem -> L0 (a_len+1 cycles)
// s_a_exe      | execute from L0 (a_len cycles)
// s_wait_drain | wait for all output rows to reach psum SRAM
// s_done       | one-cycle done pulse
`timescale 1ns/1ps
module corelet_seq #(
   parameter int row   = 8,
   parameter int col   = 8,
   parameter int len_w = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [9:0]       k_base,
   input  logic [9:0]       a_base,
   input  logic [len_w-1:0] a_len,
   input  logic [9:0]       p_base,
   input  logic             ofifo_valid,
   output logic [33:0]      inst_q,
   output logic             busy,
   output logic             done,
   output logic             err
);
   localparam int cw = len_w + 1;
   localparam logic [cw-1:0] col_c = cw'(col);
   localparam logic [cw-1:0] gap_c = cw'(row + col);
   localparam logic [33:0] idle_inst = (34'd1 << 17) | (34'd1 << 18) | (34'd1 << 29) | (34'd1 << 30);

   typedef enum logic [2:0] {
      s_idle, s_k_l0, s_k_arr, s_k_gap, s_a_l0, s_a_exe, s_wait_drain, s_done
   } state_t;

   state_t           state, nxt_state;
   logic [cw-1:0]    cnt, nxt_cnt;
   logic [9:0]       k_base_q, a_base_q, p_base_q;
   logic [len_w-1:0] a_len_q, drain_cnt;
   logic [33:0]      inst_r;
   logic [cw-1:0]    len_x;
   logic             accept, fire, tmo;

   assign accept = (state == s_idle) && start;
   assign len_x  = {1'b0, a_len_q};
   assign fire   = ((state == s_a_exe) || (state == s_wait_drain)) && ofifo_valid
                   && (drain_cnt < a_len_q);

   // Base instruction for a given phase cycle; drain bits are overlaid separately.
   function automatic logic [33:0] decode(input state_t s, input logic [cw-1:0] c,
                                          input logic [9:0] kb, input logic [9:0] ab,
                                          input logic [cw-1:0] lx);
      logic [33:0] v;
      v = idle_inst;
      case (s)
         s_k_l0: begin
            if (c < col_c) begin
               v[17]   = 1'b0;
               v[16:7] = kb + 10'(c);
            end
            if (c != '0) v[2] = 1'b1;
         end
         s_k_arr: begin
            v[3] = 1'b1;
            v[1] = 1'b1;
         end
         s_a_l0: begin
            if (c < lx) begin
               v[17]   = 1'b0;
               v[16:7] = ab + 10'(c);
            end
            if (c != '0) v[2] = 1'b1;
         end
         s_a_exe: begin
            v[3] = 1'b1;
            v[0] = 1'b1;
         end
         default: v = idle_inst;
      endcase
      return v;
   endfunction

   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt + 1'b1;
      case (state)
         s_idle: begin
            nxt_cnt = '0;
            if (start) nxt_state = s_k_l0;
         end
         s_k_l0: if (cnt == col_c) begin
            nxt_state = s_k_arr;
            nxt_cnt   = '0;
         end
         s_k_arr: if (cnt == col_c - 1'b1) begin
            nxt_state = s_k_gap;
            nxt_cnt   = '0;
         end
         s_k_gap: if (cnt == gap_c - 1'b1) begin
            nxt_state = (a_len_q == '0) ? s_done : s_a_l0;
            nxt_cnt   = '0;
         end
         s_a_l0: if (cnt == len_x) begin
            nxt_state = s_a_exe;
            nxt_cnt   = '0;
         end
         s_a_exe: if (cnt == len_x - 1'b1) begin
            nxt_state = s_wait_drain;
            nxt_cnt   = '0;
         end
         s_wait_drain: begin
            nxt_cnt = '0;
            if ((drain_cnt == a_len_q) || tmo) nxt_state = s_done;
         end
         s_done: begin
            nxt_cnt   = '0;
            nxt_state = s_idle;
         end
         default: begin
            nxt_cnt   = '0;
            nxt_state = s_idle;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= s_idle;
         cnt       <= '0;
         k_base_q  <= '0;
         a_base_q  <= '0;
         p_base_q  <= '0;
         a_len_q   <= '0;
         drain_cnt <= '0;
         inst_r    <= idle_inst;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state <= nxt_state;
         cnt   <= nxt_cnt;
         if (accept) begin
            k_base_q  <= k_base;
            a_base_q  <= a_base;
            p_base_q  <= p_base;
            a_len_q   <= a_len;
            drain_cnt <= '0;
         end else if (fire) begin
            drain_cnt <= drain_cnt + 1'b1;
         end
         inst_r <= decode(nxt_state, nxt_cnt,
                          accept ? k_base : k_base_q,
                          accept ? a_base : a_base_q,
                          accept ? {1'b0, a_len} : len_x);
         busy <= (nxt_state != s_idle);
         done <= (nxt_state == s_done);
      end
   end

   always_comb begin
      inst_q = inst_r;
      if (fire) begin
         inst_q[6]     = 1'b1;
         inst_q[28:19] = p_base_q + 10'(drain_cnt);
         inst_q[29]    = 1'b0;
         inst_q[30]    = 1'b0;
      end
   end

`ifdef CORELET_SEQ_TIMEOUT_EN
   logic [7:0] idle_cnt;
   logic       err_r;

   assign tmo = (state == s_wait_drain) && !fire && (drain_cnt != a_len_q) && (idle_cnt == 8'd254);
   assign err = err_r;

   always_ff @(posedge clk) begin
      if (!reset) begin
         idle_cnt <= '0;
         err_r    <= 1'b0;
      end else begin
         if ((state == s_wait_drain) && !fire) idle_cnt <= idle_cnt + 1'b1;
         else                                  idle_cnt <= '0;
         if (accept)   err_r <= 1'b0;
         else if (tmo) err_r <= 1'b1;
      end
   end
`else
   assign tmo = 1'b0;
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_corelet_seq.sv
// Randomized self-checking bench for corelet_seq with a phase-timeline reference model.
`timescale 1ns/1ps
module tb_corelet_seq;
   localparam int ROW = 8;
   localparam int COL = 8;
   localparam logic [33:0] IDLE = 34'h0_6006_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [9:0]  k_base = '0, a_base = '0, p_base = '0;
   logic [7:0]  a_len = '0;
   logic        ofifo_valid = 1'b0;
   logic [33:0] inst_q;
   logic        busy, done, err;

   int n_checks = 0;
   int n_errors = 0;
   bit exp_err  = 1'b0;

   corelet_seq #(.row(ROW), .col(COL), .len_w(8)) dut (
      .clk(clk), .reset(reset), .start(start), .k_base(k_base), .a_base(a_base),
      .a_len(a_len), .p_base(p_base), .ofifo_valid(ofifo_valid),
      .inst_q(inst_q), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   // Expected instruction (without drain bits) at cycle t after the accept edge.
   function automatic logic [33:0] exp_base(input int t, input int kb, input int ab, input int len);
      logic [33:0] v;
      int a0, r;
      v  = IDLE;
      a0 = 3*COL + ROW + 1;
      if (t <= COL) begin
         if (t < COL) begin
            v[17]   = 1'b0;
            v[16:7] = 10'((kb + t) % 1024);
         end
         if (t >= 1) v[2] = 1'b1;
      end else if (t <= 2*COL) begin
         v[3] = 1'b1;
         v[1] = 1'b1;
      end else if (t < a0) begin
         v = IDLE;
      end else if (len > 0 && t <= a0 + len) begin
         r = t - a0;
         if (r < len) begin
            v[17]   = 1'b0;
            v[16:7] = 10'((ab + r) % 1024);
         end
         if (r >= 1) v[2] = 1'b1;
      end else if (len > 0 && t <= a0 + 2*len) begin
         v[3] = 1'b1;
         v[0] = 1'b1;
      end
      return v;
   endfunction

   // mode 0: random ofifo_valid, 1: valid one cycle after each execute, 2: valid held low
   task automatic run_job(input int kb, input int ab, input int len, input int pb,
                          input int mode, input bit busy_start, input int abort_t);
      int a0, exe0, w0, done_t, dcnt, nf;
      bit fire, in_win, finished;
      logic [33:0] e;
      @(negedge clk);
      k_base = 10'(kb); a_base = 10'(ab); a_len = 8'(len); p_base = 10'(pb);
      start = 1'b1;
      ofifo_valid = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      check("pre_busy", 34'(busy), 34'd0);
      check("pre_err", 34'(err), 34'(exp_err));
      a0 = 3*COL + ROW + 1;
      exe0 = a0 + len + 1;
      w0 = a0 + 2*len + 1;
      done_t = (len == 0) ? a0 : -1;
      dcnt = 0;
      nf = 0;
      finished = 1'b0;
      exp_err = 1'b0;
      for (int t = 0; t < 3000; t++) begin
         @(negedge clk);
         start = busy_start && (len > 0) && (t == exe0);
         k_base = 10'($urandom); a_base = 10'($urandom); a_len = 8'($urandom); p_base = 10'($urandom);
         case (mode)
            0:       ofifo_valid = 1'($urandom_range(0, 1));
            1:       ofifo_valid = (len > 0) && (t > exe0) && (t <= exe0 + len);
            default: ofifo_valid = 1'b0;
         endcase
         if (t == abort_t) reset = 1'b0;
         #1;
         in_win = (len > 0) && (t >= exe0) && (done_t < 0 || t < done_t);
         fire = in_win && ofifo_valid && (dcnt < len);
         e = (t == done_t) ? IDLE : exp_base(t, kb, ab, len);
         if (fire) begin
            e[6]     = 1'b1;
            e[28:19] = 10'((pb + dcnt) % 1024);
            e[29]    = 1'b0;
            e[30]    = 1'b0;
         end
         check("inst_q", inst_q, e);
         check("busy", 34'(busy), 34'd1);
         check("done", 34'(done), 34'(t == done_t));
         check("err", 34'(err), 34'(exp_err && t == done_t));
         if (t == abort_t) begin
            @(negedge clk);
            start = 1'b0;
            ofifo_valid = 1'b0;
            #1;
            check("rst_inst", inst_q, IDLE);
            check("rst_busy", 34'(busy), 34'd0);
            check("rst_done", 34'(done), 34'd0);
            reset = 1'b1;
            exp_err = 1'b0;
            repeat (5) begin
               @(negedge clk);
               #1;
               check("post_rst_done", 34'(done), 34'd0);
            end
            return;
         end
         if (t == done_t) begin
            finished = 1'b1;
            break;
         end
         if (len > 0 && t >= w0 && done_t < 0) begin
            if (dcnt == len) done_t = t + 1;
`ifdef CORELET_SEQ_TIMEOUT_EN
            else if (!fire) begin
               nf++;
               if (nf == 255) begin
                  done_t = t + 1;
                  exp_err = 1'b1;
               end
            end else nf = 0;
`endif
         end
         if (fire) dcnt++;
      end
      check("job_finished", 34'(finished), 34'd1);
      @(negedge clk);
      start = 1'b0;
      ofifo_valid = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      check("end_inst", inst_q, IDLE);
      check("end_busy", 34'(busy), 34'd0);
      check("end_done", 34'(done), 34'd0);
      check("end_err", 34'(err), 34'(exp_err));
   endtask

   initial begin
      int hang_abort;
      reset = 1'b0;
      start = 1'b1;
      ofifo_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         check("hold_inst", inst_q, IDLE);
         check("hold_busy", 34'(busy), 34'd0);
         check("hold_done", 34'(done), 34'd0);
         check("hold_err", 34'(err), 34'd0);
      end
      @(negedge clk);
      reset = 1'b1;
      start = 1'b0;
      ofifo_valid = 1'b0;

      run_job(0, 16, 4, 100, 1, 1'b0, -1);
      run_job(5, 200, 0, 300, 0, 1'b0, -1);
      run_job(1020, 1019, 4, 1022, 1, 1'b0, -1);
      run_job(33, 64, 3, 500, 1, 1'b1, -1);
      run_job(10, 20, 4, 30, 0, 1'b0, COL + 3);

`ifdef CORELET_SEQ_TIMEOUT_EN
      hang_abort = -1;
`else
      hang_abort = 3*COL + ROW + 1 + 2*4 + 1 + 300;
`endif
      run_job(40, 80, 4, 120, 2, 1'b0, hang_abort);

      for (int j = 0; j < 12; j++)
         run_job(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                 int'($urandom_range(0, 6)), int'($urandom_range(0, 1023)),
                 0, 1'($urandom_range(0, 1)), -1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
